// File: rtl/video_sig_gen.sv
// Raster timing generator: pixel coordinates, syncs, active-draw, new-frame and frame count.
// Optional VIDEO_SIG_NEW_LINE_EN adds nl_out, a pulse at the end of every visible line.
module video_sig_gen #(
    parameter int ACTIVE_H      = 1280,
    parameter int H_FRONT_PORCH = 110,
    parameter int H_SYNC_WIDTH  = 40,
    parameter int H_BACK_PORCH  = 220,
    parameter int ACTIVE_V      = 720,
    parameter int V_FRONT_PORCH = 5,
    parameter int V_SYNC_WIDTH  = 5,
    parameter int V_BACK_PORCH  = 20,
    parameter int FPS           = 60
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        ad_out,
    output logic        nf_out,
`ifdef VIDEO_SIG_NEW_LINE_EN
    output logic        nl_out,
`endif
    output logic [5:0]  fc_out
);

    localparam int H_TOTAL = ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int V_TOTAL = ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(ACTIVE_H);
    localparam logic [10:0] HS_START = 11'(ACTIVE_H + H_FRONT_PORCH);
    localparam logic [10:0] HS_END   = 11'(ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT    = 10'(ACTIVE_V);
    localparam logic [9:0]  VS_START = 10'(ACTIVE_V + V_FRONT_PORCH);
    localparam logic [9:0]  VS_END   = 10'(ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH);
    localparam logic [5:0]  FC_LAST  = 6'(FPS - 1);

    // Cleared in reset so the first cycle after release shows pixel (0,0)
    // rather than (1,0); all flags are then derived from the same next pixel.
    logic        started;
    logic [10:0] h_nxt;
    logic [9:0]  v_nxt;
    logic        nf_nxt;
    logic [5:0]  fc_nxt;

    always_comb begin
        h_nxt  = '0;
        v_nxt  = '0;
        if (started) begin
            if (hcount_out == H_LAST) begin
                h_nxt = '0;
                v_nxt = (vcount_out == V_LAST) ? 10'd0 : vcount_out + 10'd1;
            end else begin
                h_nxt = hcount_out + 11'd1;
                v_nxt = vcount_out;
            end
        end
        nf_nxt = (h_nxt == H_ACT) && (v_nxt == V_ACT);
        fc_nxt = fc_out;
        if (nf_nxt) begin
            fc_nxt = (fc_out == FC_LAST) ? 6'd0 : fc_out + 6'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            started    <= 1'b0;
            hcount_out <= '0;
            vcount_out <= '0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            ad_out     <= 1'b0;
            nf_out     <= 1'b0;
            fc_out     <= '0;
        end else begin
            started    <= 1'b1;
            hcount_out <= h_nxt;
            vcount_out <= v_nxt;
            hs_out     <= (h_nxt >= HS_START) && (h_nxt < HS_END);
            vs_out     <= (v_nxt >= VS_START) && (v_nxt < VS_END);
            ad_out     <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
            nf_out     <= nf_nxt;
            fc_out     <= fc_nxt;
        end
    end

`ifdef VIDEO_SIG_NEW_LINE_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            nl_out <= 1'b0;
        end else begin
            nl_out <= (h_nxt == H_ACT) && (v_nxt < V_ACT);
        end
    end
`endif

endmodule

// File: tb/tb_video_sig_gen.sv
// Bench for video_sig_gen: a 720p instance for line timing and a small-raster
// instance (16x8 pixels per frame) for vertical timing, frame count and reset.
module tb_video_sig_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [10:0] h_d, h_s;
    logic [9:0]  v_d, v_s;
    logic        hs_d, hs_s, vs_d, vs_s, ad_d, ad_s, nf_d, nf_s;
    logic [5:0]  fc_d, fc_s;
`ifdef VIDEO_SIG_NEW_LINE_EN
    logic        nl_d, nl_s;
`endif

    always #5 clk = ~clk;

    video_sig_gen u_d (
        .clk_in(clk), .rst_in(rst),
        .hcount_out(h_d), .vcount_out(v_d),
        .hs_out(hs_d), .vs_out(vs_d), .ad_out(ad_d), .nf_out(nf_d),
`ifdef VIDEO_SIG_NEW_LINE_EN
        .nl_out(nl_d),
`endif
        .fc_out(fc_d)
    );

    // Small raster: H 8+2+3+3=16, hs [10,13); V 4+1+2+1=8, vs [5,7); nf at (8,4)
    video_sig_gen #(
        .ACTIVE_H(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .H_BACK_PORCH(3),
        .ACTIVE_V(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2), .V_BACK_PORCH(1),
        .FPS(60)
    ) u_s (
        .clk_in(clk), .rst_in(rst),
        .hcount_out(h_s), .vcount_out(v_s),
        .hs_out(hs_s), .vs_out(vs_s), .ad_out(ad_s), .nf_out(nf_s),
`ifdef VIDEO_SIG_NEW_LINE_EN
        .nl_out(nl_s),
`endif
        .fc_out(fc_s)
    );

    typedef struct {
        int sel;  // 0 = 720p instance, 1 = small instance
        int n;    // cycles after the first post-reset sample
        int h;
        int v;
        bit hs;
        bit vs;
        bit ad;
        bit nf;
        int fc;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(int sel, int n, int h, int v, bit hs, bit vs, bit ad, bit nf, int fc);
        vec_t e;
        e.sel = sel; e.n = n; e.h = h; e.v = v;
        e.hs = hs; e.vs = vs; e.ad = ad; e.nf = nf; e.fc = fc;
        return e;
    endfunction

    function automatic logic [63:0] pack(int h, int v, bit hs, bit vs, bit ad, bit nf, int fc);
        logic [63:0] p;
        p = '0;
        p[32:22] = 11'(h);
        p[21:12] = 10'(v);
        p[11]    = hs;
        p[10]    = vs;
        p[9]     = ad;
        p[8]     = nf;
        p[5:0]   = 6'(fc);
        return p;
    endfunction

    function automatic logic [63:0] act_s();
        return pack(int'(h_s), int'(v_s), hs_s, vs_s, ad_s, nf_s, int'(fc_s));
    endfunction

    function automatic logic [63:0] act_d();
        return pack(int'(h_d), int'(v_d), hs_d, vs_d, ad_d, nf_d, int'(fc_d));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        check({name, "_small"}, act_s(), 64'd0);
        check({name, "_720p"}, act_d(), 64'd0);
`ifdef VIDEO_SIG_NEW_LINE_EN
        check({name, "_nl"}, {62'd0, nl_s, nl_d}, 64'd0);
`endif
    endtask

    initial begin
        int cyc;
        int pulses;
        int nf_seen;
        int nl_seen;
        int eh, ev;
        bit enf;

        // entries in ascending n
        tbl.push_back(mk(1,    0,    0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0,    0,    0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1,    7,    7, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1,    8,    8, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,    9,    9, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,   10,   10, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1,   12,   12, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1,   13,   13, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,   15,   15, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,   16,    0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1,   71,    7, 4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,   72,    8, 4, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1,   73,    9, 4, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,   79,   15, 4, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,   80,    0, 5, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1,  111,   15, 6, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1,  112,    0, 7, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,  127,   15, 7, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,  128,    0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1,  200,    8, 4, 0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 1279, 1279, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1280, 1280, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1389, 1389, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1390, 1390, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1429, 1429, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1430, 1430, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1649, 1649, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1650,    0, 1, 0, 0, 1, 0, 0));

        // reset held for three cycles, then released
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_zero("reset_hold");
        end
        rst = 1'b0;
        step();
        cyc = 0;

        foreach (tbl[i]) begin
            while (cyc < tbl[i].n) begin
                step();
                cyc++;
            end
            check($sformatf("vec%0d_n%0d", i, tbl[i].n),
                  (tbl[i].sel == 1) ? act_s() : act_d(),
                  pack(tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].ad, tbl[i].nf, tbl[i].fc));
        end

        // 61 small frames from a fresh reset, every pixel against the raster model
        rst = 1'b1;
        step();
        check_zero("reset_sweep");
        rst = 1'b0;
        pulses  = 0;
        nf_seen = 0;
        nl_seen = 0;
        for (int k = 0; k < 61 * 128; k++) begin
            step();
            eh  = k % 16;
            ev  = (k / 16) % 8;
            enf = (eh == 8) && (ev == 4);
            if (enf) pulses++;
            if (nf_s) nf_seen++;
            check($sformatf("sweep_k%0d", k), act_s(),
                  pack(eh, ev, (eh >= 10) && (eh < 13), (ev >= 5) && (ev < 7),
                       (eh < 8) && (ev < 4), enf, pulses % 60));
`ifdef VIDEO_SIG_NEW_LINE_EN
            if (nl_s) nl_seen++;
            check($sformatf("nl_k%0d", k), 64'(nl_s), 64'((eh == 8) && (ev < 4)));
`endif
        end
        check("nf_pulse_count", 64'(nf_seen), 64'd61);
`ifdef VIDEO_SIG_NEW_LINE_EN
        check("nl_pulse_count", 64'(nl_seen), 64'd244);
`endif

        // one-cycle reset in mid-frame, fc nonzero beforehand
        repeat (37) step();
        rst = 1'b1;
        step();
        check_zero("reset_mid");
        rst = 1'b0;
        step();
        check("mid_restart", act_s(), pack(0, 0, 0, 0, 1, 0, 0));
        nf_seen = 0;
        for (int k = 1; k < 72; k++) begin
            step();
            if (nf_s) nf_seen++;
        end
        check("mid_no_early_nf", 64'(nf_seen), 64'd0);
        step();
        check("mid_first_nf", act_s(), pack(8, 4, 0, 0, 0, 1, 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/video_sig_gen.md
Name: video_sig_gen

Overview:
Raster timing generator for the 720p60 HDMI path. It produces the hcount/vcount pixel coordinates consumed by every sprite and screen generator, including the game-over/wall-depth screens. It also produces the sync, active-draw, new-frame and frame-count signals used by the TMDS encoder and the game logic. It sits directly upstream of all pixel generators and runs in the 74.25 MHz pixel clock domain.

Parameters:
ACTIVE_H, 1280, visible pixels per line
H_FRONT_PORCH, 110, pixels after the active region before hsync
H_SYNC_WIDTH, 40, hsync pulse width in pixels
H_BACK_PORCH, 220, pixels after hsync before the next line
ACTIVE_V, 720, visible lines per frame
V_FRONT_PORCH, 5, lines after the active region before vsync
V_SYNC_WIDTH, 5, vsync pulse width in lines
V_BACK_PORCH, 20, lines after vsync before the next frame
FPS, 60, frame-count modulus

Ports:
clk_in  input  1  pixel clock
rst_in  input  1  synchronous active-high reset
hcount_out  output  11  current pixel column, 0..H_TOTAL-1
vcount_out  output  10  current line, 0..V_TOTAL-1
hs_out  output  1  horizontal sync, active high
vs_out  output  1  vertical sync, active high
ad_out  output  1  active draw: hcount_out<ACTIVE_H and vcount_out<ACTIVE_V
nf_out  output  1  new-frame single-cycle pulse
fc_out  output  6  frame counter, 0..FPS-1

Behaviour:
- Clocking and reset: one clock domain, clk_in. Reset is synchronous and active-high on rst_in.
- Derived constants:
  - H_TOTAL = sum of the four H parameters (1650).
  - V_TOTAL = sum of the four V parameters (750).
- Reset state: while rst_in is sampled high, every output is driven to 0, including ad_out, even though (0,0) is an active pixel.
- Counters:
  - First edge after rst_in falls: hcount_out=0, vcount_out=0, ad_out=1.
  - hcount increments by 1 on every clock.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At vcount=V_TOTAL-1 together with hcount=H_TOTAL-1, both counters wrap to 0.
  - No counter ever exceeds its TOTAL-1.
- Output alignment: all outputs are registered and mutually aligned. In any cycle, hs_out, vs_out, ad_out and nf_out describe exactly the pixel shown on hcount_out/vcount_out that cycle, with zero skew between them.
- hs_out: high iff ACTIVE_H+H_FRONT_PORCH <= hcount_out < ACTIVE_H+H_FRONT_PORCH+H_SYNC_WIDTH, i.e. [1390,1430).
- vs_out: high iff ACTIVE_V+V_FRONT_PORCH <= vcount_out < ACTIVE_V+V_FRONT_PORCH+V_SYNC_WIDTH, i.e. [725,730).
  - vs_out is asserted for whole lines, independent of hcount.
- nf_out: high for exactly one cycle per frame, when hcount_out==ACTIVE_H and vcount_out==ACTIVE_V (1280,720). This is the first blanking pixel after the last visible line.
- fc_out:
  - Updates in the same cycle nf_out is asserted, so fc_out shows the new value alongside the nf pulse.
  - Increments modulo FPS: 59 -> 0.
  - Holds its value otherwise.
- Reset mid-operation: on the first cycle after reset, counters, fc_out and all flags restart from the post-reset state above.
  - No partial nf pulse is emitted on reset entry or exit.
- Width rule: all compares are unsigned at the declared counter widths. Parameters must satisfy H_TOTAL<=2048, V_TOTAL<=1024 and FPS<=64.

Optional Feature:
- Macro: VIDEO_SIG_NEW_LINE_EN.
- When defined:
  - Adds output port nl_out (1 bit).
  - nl_out is a one-cycle pulse when hcount_out==ACTIVE_H and vcount_out<ACTIVE_V, i.e. the end of each visible line; 720 pulses per frame.
  - nl_out is aligned with the other outputs and is 0 during reset.
- When undefined: the nl_out port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release: hold rst_in for 3 cycles (all outputs 0), then release -> next cycle hcount=0, vcount=0, ad=1, hs=0, vs=0, nf=0, fc=0.
- Horizontal timing: run one line ->
  - ad=1 for hcount 0..1279, then ad=0 from 1280.
  - hs=1 exactly for hcount 1390..1429 (40 cycles).
  - After hcount=1649, hcount=0 and vcount=1.
- Vertical timing and wrap:
  - vs=1 for all of lines 725..729 and 0 elsewhere.
  - After (1649,749) the next pixel is (0,0).
  - One full frame is 1,237,500 cycles.
- New frame and fc wrap: run 61 frames -> exactly one nf pulse per frame at (1280,720); fc steps 0,1,...,59,0,1.
- Reset mid-frame: assert rst_in at (800,400) for 1 cycle -> outputs 0 during reset; next cycle (0,0), fc=0; no nf pulse until (1280,720).
- With VIDEO_SIG_NEW_LINE_EN: one frame -> 720 nl pulses, each at hcount=1280; none for vcount 720..749.
